// File: rtl/weight_load_if.sv
// Weight stream handshake between the upstream weight source and weight_load_ctrl.
// The master drives valid/data and the slave drives ready.
interface weight_load_if;
  logic       w_valid;
  logic [4:0] w_data;
  logic       w_ready;

  modport master (
    output w_valid,
    output w_data,
    input  w_ready
  );

  modport slave (
    input  w_valid,
    input  w_data,
    output w_ready
  );
endinterface

// File: rtl/weight_load_ctrl.sv
// Loads SIZE*SIZE weights into the weight memory, then streams SIZE columns via PreLoadWeight.
// Every output is registered from the next-state decode, so no input reaches an output combinationally.
//
// state     | meaning
// ----------+-----------------------------------------------------------------
// S_IDLE    | after reset; memory write disabled, waiting for start_load
// S_LOAD    | w_ready high; each accepted beat is written at the write counter
// S_FLUSH   | one cycle that keeps the write enabled for the last address
// S_LOADED  | weights valid; waits for preload_req or a new start_load
// S_PRELOAD | PreLoadWeight high for exactly SIZE cycles
module weight_load_ctrl #(
  parameter int SIZE       = 8,
  parameter int MEM_SIZE   = SIZE * SIZE,
  parameter int ADDR_WIDTH = $clog2(MEM_SIZE),
  parameter int CNT_WIDTH  = $clog2(SIZE) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_load,
  weight_load_if.slave          w_bus,
  input  logic                  preload_req,
  output logic [ADDR_WIDTH-1:0] Weight_Mem_Address_in,
  output logic [4:0]            Weight_Data,
  output logic                  load_mem_done,
  output logic                  PreLoadWeight,
  output logic                  preload_done,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_LOADED,
    S_PRELOAD
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);
  localparam logic [CNT_WIDTH-1:0]  LAST_CNT  = CNT_WIDTH'(SIZE - 1);

  state_t                state_q, state_nxt;
  logic [ADDR_WIDTH-1:0] wr_cnt_q, wr_cnt_nxt;
  logic [CNT_WIDTH-1:0]  pl_cnt_q, pl_cnt_nxt;
  logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
  logic [4:0]            data_q, data_nxt;
  logic                  w_ready_q, w_ready_nxt;
  logic                  done_q, done_nxt;
  logic                  plw_q, plw_nxt;
  logic                  pl_done_q, pl_done_nxt;
  logic                  busy_q, busy_nxt;
  logic                  accept;

  // w_ready_q is high exactly while state_q is S_LOAD, so the state alone qualifies a beat.
  assign accept = (state_q == S_LOAD) && w_bus.w_valid;

  always_comb begin
    state_nxt  = state_q;
    wr_cnt_nxt = wr_cnt_q;
    pl_cnt_nxt = pl_cnt_q;
    addr_nxt   = addr_q;
    data_nxt   = data_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_load) begin
          state_nxt  = S_LOAD;
          wr_cnt_nxt = '0;
        end
      end

      S_LOAD: begin
        if (accept) begin
          addr_nxt = wr_cnt_q;
          data_nxt = w_bus.w_data;
          if (wr_cnt_q == LAST_ADDR) begin
            state_nxt = S_FLUSH;
          end else begin
            wr_cnt_nxt = wr_cnt_q + ADDR_WIDTH'(1);
          end
        end
      end

      S_FLUSH: begin
        state_nxt = S_LOADED;
      end

      S_LOADED: begin
        if (start_load) begin
          state_nxt  = S_LOAD;
          wr_cnt_nxt = '0;
        end else if (preload_req) begin
          state_nxt  = S_PRELOAD;
          pl_cnt_nxt = '0;
        end
      end

      S_PRELOAD: begin
        // The memory column index does not wrap, so the run must stop at exactly SIZE cycles.
        if (pl_cnt_q == LAST_CNT) begin
          state_nxt  = S_LOADED;
          pl_cnt_nxt = '0;
        end else begin
          pl_cnt_nxt = pl_cnt_q + CNT_WIDTH'(1);
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    w_ready_nxt = (state_nxt == S_LOAD);
    done_nxt    = !((state_nxt == S_LOAD) || (state_nxt == S_FLUSH));
    plw_nxt     = (state_nxt == S_PRELOAD);
    pl_done_nxt = (state_q == S_PRELOAD) && (state_nxt == S_LOADED);
    busy_nxt    = (state_nxt == S_LOAD) || (state_nxt == S_FLUSH) ||
                  (state_nxt == S_PRELOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wr_cnt_q  <= '0;
      pl_cnt_q  <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      w_ready_q <= 1'b0;
      done_q    <= 1'b1;
      plw_q     <= 1'b0;
      pl_done_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      wr_cnt_q  <= wr_cnt_nxt;
      pl_cnt_q  <= pl_cnt_nxt;
      addr_q    <= addr_nxt;
      data_q    <= data_nxt;
      w_ready_q <= w_ready_nxt;
      done_q    <= done_nxt;
      plw_q     <= plw_nxt;
      pl_done_q <= pl_done_nxt;
      busy_q    <= busy_nxt;
    end
  end

  assign w_bus.w_ready         = w_ready_q;
  assign Weight_Mem_Address_in = addr_q;
  assign Weight_Data           = data_q;
  assign load_mem_done         = done_q;
  assign PreLoadWeight         = plw_q;
  assign preload_done          = pl_done_q;
  assign busy                  = busy_q;

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Directed bench for weight_load_ctrl with a behavioural model of the downstream weight memory.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_weight_load_ctrl;
  localparam int SIZE = 8;
  localparam int MEM  = SIZE * SIZE;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_load = 1'b0;
  logic       preload_req = 1'b0;
  logic [5:0] addr;
  logic [4:0] data;
  logic       load_mem_done, plw, preload_done, busy;

  weight_load_if wbus ();

  weight_load_ctrl #(.SIZE(SIZE)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .start_load            (start_load),
    .w_bus                 (wbus.slave),
    .preload_req           (preload_req),
    .Weight_Mem_Address_in (addr),
    .Weight_Data           (data),
    .load_mem_done         (load_mem_done),
    .PreLoadWeight         (plw),
    .preload_done          (preload_done),
    .busy                  (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [4:0] mem [MEM];
  int plw_run = 0;
  int plw_max = 0;
  int pd_total = 0;
  logic [5:0] exp_addr;
  logic [4:0] exp_data;

  // Downstream memory: writes while load_mem_done is low; also tracks preload run lengths.
  always @(negedge clk) begin
    if (load_mem_done === 1'b0) mem[addr] = data;
    if (plw === 1'b1) begin
      plw_run = plw_run + 1;
      if (plw_run > plw_max) plw_max = plw_run;
    end else begin
      plw_run = 0;
    end
    if (preload_done === 1'b1) pd_total = pd_total + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    foreach (mem[i]) mem[i] = 'x;
  endtask

  task automatic chk_mem();
    for (int i = 0; i < MEM; i++) chk($sformatf("mem[%0d]", i), 32'(mem[i]), 32'(i % 32));
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_done"}, 32'(load_mem_done), 32'd1);
    chk({tag, "_addr"}, 32'(addr), 32'd0);
    chk({tag, "_data"}, 32'(data), 32'd0);
    chk({tag, "_wready"}, 32'(wbus.w_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_plw"}, 32'(plw), 32'd0);
    chk({tag, "_pdone"}, 32'(preload_done), 32'd0);
  endtask

  // Pulse start_load and check the first LOAD cycle, which still shows the old address/data.
  task automatic start();
    start_load = 1'b1;
    step();
    start_load = 1'b0;
    chk("start_wready", 32'(wbus.w_ready), 32'd1);
    chk("start_done", 32'(load_mem_done), 32'd0);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_addr", 32'(addr), 32'(exp_addr));
    chk("start_data", 32'(data), 32'(exp_data));
  endtask

  task automatic do_load(input bit gaps, input int first);
    int acc = first;
    int cyc = 0;
    while (acc < MEM && cyc < 2000) begin
      wbus.w_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      wbus.w_data  = 5'(acc % 32);
      step();
      cyc++;
      if (wbus.w_valid) begin
        exp_addr = 6'(acc);
        exp_data = 5'(acc % 32);
        acc++;
      end
      chk("load_addr", 32'(addr), 32'(exp_addr));
      chk("load_data", 32'(data), 32'(exp_data));
      chk("load_wready", 32'(wbus.w_ready), 32'(acc < MEM));
      chk("load_done_low", 32'(load_mem_done), 32'd0);
    end
    wbus.w_valid = 1'b0;
    chk("load_beats", 32'(acc), 32'(MEM));
    step();
    chk("load_done_rise", 32'(load_mem_done), 32'd1);
    chk("load_busy_end", 32'(busy), 32'd0);
    chk("load_wready_end", 32'(wbus.w_ready), 32'd0);
  endtask

  task automatic do_preload(input bit inject);
    preload_req = 1'b1;
    step();
    preload_req = 1'b0;
    for (int k = 0; k < SIZE; k++) begin
      chk("pre_plw", 32'(plw), 32'd1);
      chk("pre_pdone", 32'(preload_done), 32'd0);
      chk("pre_busy", 32'(busy), 32'd1);
      if (inject && k == 3) begin
        start_load   = 1'b1;
        preload_req  = 1'b1;
        wbus.w_valid = 1'b1;
        wbus.w_data  = 5'd9;
      end
      step();
      start_load   = 1'b0;
      preload_req  = 1'b0;
      wbus.w_valid = 1'b0;
    end
    chk("pre_plw_fall", 32'(plw), 32'd0);
    chk("pre_pdone_pulse", 32'(preload_done), 32'd1);
    chk("pre_busy_end", 32'(busy), 32'd0);
    step();
    chk("pre_pdone_clear", 32'(preload_done), 32'd0);
    chk("pre_plw_stay", 32'(plw), 32'd0);
    chk("pre_done_hold", 32'(load_mem_done), 32'd1);
    chk("pre_addr_hold", 32'(addr), 32'(exp_addr));
  endtask

  initial begin
    wbus.w_valid = 1'b0;
    wbus.w_data  = '0;
    exp_addr = '0;
    exp_data = '0;
    clear_mem();
    repeat (3) step();
    rst = 1'b0;
    step();
    chk_idle_outputs("reset");

    // Back-to-back load of 64 beats
    start();
    do_load(1'b0, 0);
    chk_mem();

    // Load with random valid gaps, starting from LOADED
    clear_mem();
    start();
    do_load(1'b1, 0);
    chk_mem();

    // Preload sequence
    do_preload(1'b0);
    chk("pd_count_1", 32'(pd_total), 32'd1);

    // start_load and preload_req together: start wins
    start_load  = 1'b1;
    preload_req = 1'b1;
    step();
    start_load  = 1'b0;
    preload_req = 1'b0;
    chk("both_plw", 32'(plw), 32'd0);
    chk("both_done", 32'(load_mem_done), 32'd0);
    chk("both_wready", 32'(wbus.w_ready), 32'd1);
    chk("both_addr", 32'(addr), 32'(exp_addr));
    do_load(1'b0, 0);

    // Reset after beat 30 of a load
    start();
    for (int i = 0; i <= 30; i++) begin
      wbus.w_valid = 1'b1;
      wbus.w_data  = 5'(i % 32);
      step();
      chk("part_addr", 32'(addr), 32'(i));
    end
    rst = 1'b1;
    wbus.w_valid = 1'b0;
    step();
    rst = 1'b0;
    chk_idle_outputs("midrst");
    exp_addr = '0;
    exp_data = '0;
    step();
    chk("midrst_no_pdone", 32'(pd_total), 32'd1);
    chk("midrst_idle_done", 32'(load_mem_done), 32'd1);
    clear_mem();
    start();
    do_load(1'b0, 0);
    chk_mem();

    // w_valid while LOADED is ignored, then preload with start_load injected mid-run
    wbus.w_valid = 1'b1;
    wbus.w_data  = 5'd7;
    step();
    step();
    wbus.w_valid = 1'b0;
    chk("loaded_wvalid_addr", 32'(addr), 32'd63);
    chk("loaded_wvalid_data", 32'(data), 32'd31);
    chk("loaded_wready", 32'(wbus.w_ready), 32'd0);
    do_preload(1'b1);
    chk("pd_count_2", 32'(pd_total), 32'd2);
    chk("plw_max_run", 32'(plw_max), 32'(SIZE));

    // w_valid and preload_req in IDLE are ignored
    rst = 1'b1;
    step();
    rst = 1'b0;
    wbus.w_valid = 1'b1;
    wbus.w_data  = 5'd21;
    preload_req  = 1'b1;
    step();
    step();
    wbus.w_valid = 1'b0;
    preload_req  = 1'b0;
    chk_idle_outputs("idle_ignore");
    step();
    chk("idle_no_plw", 32'(plw), 32'd0);
    chk("idle_pd_total", 32'(pd_total), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end
endmodule
